fifo_stream_reader: RTL and testbench

- Read-side controller for sync_fifo: pops words from the FIFO and presents them downstream as a valid/ready stream.
- Groups words into packets of PKT_LEN words and flags the last word of each packet.
- Absorbs the FIFO's registered read latency with a 2-entry output buffer, so throughput is 1 word/cycle with no bubbles.
- Sits between sync_fifo (rd/dataout/empty) and any stream consumer.

---
 rtl/fifo_stream_reader_pkg.sv | 14 +
 rtl/fifo_stream_reader_skid_buf.sv | 81 ++++++++
 rtl/fifo_stream_reader.sv | 105 ++++++++++
 tb/tb_fifo_stream_reader.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_stream_reader_pkg.sv
// Purpose: shared constants for the FIFO stream reader: FSM state codes and output buffer depth.
// Latency: n/a (constants only).
// Backpressure: n/a.
package fifo_stream_reader_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_STOP = 2'd2;

    // Two entries cover one word sitting at the head plus one word in
    // flight from the FIFO's registered read port.
    localparam int BUF_DEPTH = 2;

endpackage

// File: rtl/fifo_stream_reader_skid_buf.sv
// Purpose: 2-entry {last, data} buffer that decouples FIFO read latency from the stream consumer.
// Latency: a write at edge N is visible at the head after edge N (head valid the next cycle).
// Backpressure: head held stable until popped; writer must respect occ (no overflow check here).
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   wr, wr_last,      push strobe with its {last, data} payload
//   wr_data
//   rd                pop strobe (ignored when empty)
//   vld               buffer non-empty
//   rd_last, rd_data  head entry
//   occ               current occupancy 0..2
module stream_skid_buf
    import fifo_stream_reader_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr,
    input  logic          wr_last,
    input  logic [DW-1:0] wr_data,
    input  logic          rd,
    output logic          vld,
    output logic          rd_last,
    output logic [DW-1:0] rd_data,
    output logic [1:0]    occ
);

    logic [DW-1:0] d0, d1;
    logic          l0, l1;
    logic          rd_ok;

    assign rd_ok   = rd & vld;
    assign vld     = (occ != 2'd0);
    assign rd_data = d0;
    assign rd_last = l0;

    // Entry 0 is always the head; entry 1 only holds data when occ == 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d0  <= '0;
            d1  <= '0;
            l0  <= 1'b0;
            l1  <= 1'b0;
            occ <= 2'd0;
        end else begin
            case ({wr, rd_ok})
                2'b10: begin
                    if (occ == 2'd0) begin
                        d0 <= wr_data;
                        l0 <= wr_last;
                    end else begin
                        d1 <= wr_data;
                        l1 <= wr_last;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    d0  <= d1;
                    l0  <= l1;
                    occ <= occ - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; new word goes behind whatever remains.
                    if (occ == 2'd1) begin
                        d0 <= wr_data;
                        l0 <= wr_last;
                    end else if (occ == 2'(BUF_DEPTH)) begin
                        d0 <= d1;
                        l0 <= l1;
                        d1 <= wr_data;
                        l1 <= wr_last;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_stream_reader.sv
// Purpose: pops sync_fifo words and presents them as a valid/ready stream framed into PKT_LEN-word packets.
// Latency: first word valid 2 cycles after entering RUN; 1 word/cycle sustained thereafter.
// Backpressure: m_ready low holds m_data/m_last; reads stop once buffer plus in-flight would exceed 2.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   en                         run enable
//   fifo_empty, fifo_dataout   sync_fifo read side (data valid 1 cycle after fifo_rd)
//   fifo_rd                    FIFO pop strobe (combinational)
//   m_data, m_valid, m_last,   output stream
//   m_ready
//   busy                       high in RUN or STOP
//   pkt_done                   pulse the cycle after an accepted m_last
module fifo_stream_reader
    import fifo_stream_reader_pkg::*;
#(
    parameter int DW      = 8,
    parameter int PKT_LEN = 16,
    parameter int CW      = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          fifo_empty,
    input  logic [DW-1:0] fifo_dataout,
    output logic          fifo_rd,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    output logic          m_last,
    input  logic          m_ready,
    output logic          busy,
    output logic          pkt_done
);

    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic          inflight;
    logic          inflight_last;
    logic [1:0]    occ;
    logic          pop;
    logic          issue_last;
    logic          issue_ok;
    logic [2:0]    committed;

    assign pop        = m_valid & m_ready;
    assign issue_last = (cnt == CW'(PKT_LEN - 1));

    // Slots already spoken for once this cycle's pop leaves the buffer.
    assign committed  = {1'b0, occ} + {2'b0, inflight} - {2'b0, pop};

    // STOP only finishes the packet in progress; a zero counter means it is done.
    assign issue_ok   = (state == ST_RUN) || ((state == ST_STOP) && (cnt != '0));
    assign fifo_rd    = issue_ok && !fifo_empty && (committed < 3'(BUF_DEPTH));
    assign busy       = (state == ST_RUN) || (state == ST_STOP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (en) state <= ST_RUN;
                ST_RUN: begin
                    if (!en) state <= (cnt != '0) ? ST_STOP : ST_IDLE;
                end
                ST_STOP: begin
                    if (en)
                        state <= ST_RUN;
                    else if ((cnt == '0) && (occ == 2'd0) && !inflight)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Counter tracks issued words, so last is decided at issue time and
    // travels with the word through the in-flight tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt           <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            pkt_done      <= 1'b0;
        end else begin
            if (fifo_rd) cnt <= issue_last ? '0 : cnt + CW'(1);
            inflight      <= fifo_rd;
            inflight_last <= fifo_rd & issue_last;
            pkt_done      <= pop & m_last;
        end
    end

    stream_skid_buf #(.DW(DW)) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr      (inflight),
        .wr_last (inflight_last),
        .wr_data (fifo_dataout),
        .rd      (pop),
        .vld     (m_valid),
        .rd_last (m_last),
        .rd_data (m_data),
        .occ     (occ)
    );

endmodule

// File: tb/tb_fifo_stream_reader.sv
module tb_fifo_stream_reader;

    localparam int DW      = 8;
    localparam int PKT_LEN = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_dataout = '0;
    logic          fifo_rd;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_last;
    logic          m_ready = 1'b0;
    logic          busy;
    logic          pkt_done;

    fifo_stream_reader #(.DW(DW), .PKT_LEN(PKT_LEN), .CW(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .fifo_empty   (fifo_empty),
        .fifo_dataout (fifo_dataout),
        .fifo_rd      (fifo_rd),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_last       (m_last),
        .m_ready      (m_ready),
        .busy         (busy),
        .pkt_done     (pkt_done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: the upstream FIFO contents, words expected downstream
    // (in order, with last computed from the issue index), and the count of
    // words popped from the FIFO but not yet accepted downstream.
    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_dat[$];
    logic          exp_last[$];
    int            issued = 0;
    int            outstanding = 0;
    int            accepted = 0;
    int            lasts_seen = 0;
    int            dones_seen = 0;
    bit            exp_pkt_done = 1'b0;
    bit            prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;

    task automatic tick();
        bit            rd_s, acc, el;
        logic [DW-1:0] ed, d;
        @(negedge clk);
        rd_s = fifo_rd;
        acc  = m_valid && m_ready;
        el   = 1'b0;
        if (rd_s) begin
            vectors++;
            if (fifo_empty) begin
                miscompares++;
                $display("FAIL rd_when_empty: fifo_rd=1 fifo_empty=%0b required no read", fifo_empty);
            end
            vectors++;
            if (outstanding - (acc ? 1 : 0) >= 2) begin
                miscompares++;
                $display("FAIL rd_buf_full: read issued with %0d words committed, required <2",
                         outstanding - (acc ? 1 : 0));
            end
        end
        if (prev_stall) begin
            vectors++;
            if (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last) begin
                miscompares++;
                $display("FAIL stall_hold: got v=%0b d=%0h l=%0b required v=1 d=%0h l=%0b",
                         m_valid, m_data, m_last, prev_data, prev_last);
            end
        end
        vectors++;
        if (pkt_done !== exp_pkt_done) begin
            miscompares++;
            $display("FAIL pkt_done: got %0b required %0b", pkt_done, exp_pkt_done);
        end
        if (pkt_done === 1'b1) dones_seen++;
        if (acc) begin
            vectors++;
            if (exp_dat.size() == 0) begin
                miscompares++;
                $display("FAIL spurious_word: got d=%0h with no word required", m_data);
            end else begin
                ed = exp_dat.pop_front();
                el = exp_last.pop_front();
                if (m_data !== ed || m_last !== el) begin
                    miscompares++;
                    $display("FAIL word: got d=%0h l=%0b required d=%0h l=%0b", m_data, m_last, ed, el);
                end
            end
            accepted++;
            if (m_last === 1'b1) lasts_seen++;
        end
        exp_pkt_done = acc && el;
        prev_stall   = m_valid && !m_ready;
        prev_data    = m_data;
        prev_last    = m_last;
        @(posedge clk);
        #1;
        if (rd_s && fifo_q.size() > 0) begin
            d = fifo_q.pop_front();
            fifo_dataout = d;
            exp_dat.push_back(d);
            exp_last.push_back((issued % PKT_LEN) == PKT_LEN - 1);
            issued++;
            outstanding++;
        end
        if (acc) outstanding--;
        fifo_empty = (fifo_q.size() == 0);
    endtask

    task automatic push(input logic [DW-1:0] d);
        fifo_q.push_back(d);
        fifo_empty = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        vectors++;
        if ({fifo_rd, m_valid, m_data, m_last, busy, pkt_done} !== '0) begin
            miscompares++;
            $display("FAIL %s: rd=%0b v=%0b d=%0h l=%0b busy=%0b done=%0b required all 0",
                     tag, fifo_rd, m_valid, m_data, m_last, busy, pkt_done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        check_all_zero("reset_outputs");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        tick();
        check_all_zero("idle_after_reset");
    endtask

    task automatic test_stream();
        int base, first, last_cyc, lbase, dbase;
        base = accepted; lbase = lasts_seen; dbase = dones_seen;
        first = -1; last_cyc = -1;
        for (int i = 0; i < 32; i++) push(DW'(i));
        m_ready = 1'b1;
        en = 1'b1;
        for (int cyc = 0; cyc < 200 && accepted - base < 32; cyc++) begin
            tick();
            if (first < 0 && accepted > base) first = cyc;
            last_cyc = cyc;
        end
        tick();
        vectors++;
        if (accepted - base != 32) begin
            miscompares++;
            $display("FAIL stream_count: got %0d words required 32", accepted - base);
        end
        vectors++;
        if (first != 3) begin
            miscompares++;
            $display("FAIL stream_latency: first word at tick %0d required 3", first);
        end
        vectors++;
        if (last_cyc - first != 31) begin
            miscompares++;
            $display("FAIL stream_rate: 32 words over %0d ticks required 31", last_cyc - first);
        end
        vectors++;
        if (lasts_seen - lbase != 2 || dones_seen - dbase != 2) begin
            miscompares++;
            $display("FAIL stream_packets: lasts=%0d dones=%0d required 2 and 2",
                     lasts_seen - lbase, dones_seen - dbase);
        end
    endtask

    task automatic test_backpressure();
        int base;
        base = accepted;
        for (int i = 0; i < 32; i++) push(DW'($urandom));
        for (int cyc = 0; cyc < 400 && accepted - base < 32; cyc++) begin
            if (cyc < 40) m_ready = ~m_ready;
            else          m_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        m_ready = 1'b1;
        vectors++;
        if (accepted - base != 32) begin
            miscompares++;
            $display("FAIL bp_count: got %0d words required 32", accepted - base);
        end
    endtask

    task automatic test_underflow();
        int base, lbase;
        base = accepted; lbase = lasts_seen;
        for (int i = 0; i < 5; i++) push(DW'(8'h40 + i));
        for (int cyc = 0; cyc < 40; cyc++) tick();
        vectors++;
        if (accepted - base != 5 || m_valid !== 1'b0 || fifo_rd !== 1'b0) begin
            miscompares++;
            $display("FAIL underflow_stall: words=%0d v=%0b rd=%0b required 5 0 0",
                     accepted - base, m_valid, fifo_rd);
        end
        for (int i = 0; i < 11; i++) push(DW'(8'h80 + i));
        for (int cyc = 0; cyc < 100 && accepted - base < 16; cyc++) tick();
        tick();
        vectors++;
        if (accepted - base != 16 || lasts_seen - lbase != 1) begin
            miscompares++;
            $display("FAIL underflow_resume: words=%0d lasts=%0d required 16 1",
                     accepted - base, lasts_seen - lbase);
        end
    endtask

    task automatic test_stop();
        int ibase, abase, cyc;
        ibase = issued; abase = accepted;
        for (int i = 0; i < 24; i++) push(DW'(8'hA0 + i));
        for (cyc = 0; cyc < 100 && issued - ibase < 8; cyc++) tick();
        en = 1'b0;
        tick();
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL stop_busy: got busy=%0b required 1", busy);
        end
        for (cyc = 0; cyc < 100 && busy === 1'b1; cyc++) tick();
        vectors++;
        if (issued - ibase != 16 || accepted - abase != 16 || fifo_q.size() != 8 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL stop_drain: issued=%0d acc=%0d left=%0d busy=%0b required 16 16 8 0",
                     issued - ibase, accepted - abase, fifo_q.size(), busy);
        end
        ibase = issued;
        for (int i = 0; i < 10; i++) tick();
        vectors++;
        if (issued != ibase) begin
            miscompares++;
            $display("FAIL stop_idle_reads: got %0d reads required 0", issued - ibase);
        end
    endtask

    task automatic test_reset_mid();
        int base, first_last, lbase;
        en = 1'b1;
        m_ready = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        vectors++;
        if (outstanding != 2 || m_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset_fill: buffered=%0d v=%0b required 2 1", outstanding, m_valid);
        end
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset_outputs");
        exp_dat.delete();
        exp_last.delete();
        issued = 0; outstanding = 0;
        prev_stall = 1'b0; exp_pkt_done = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 14; i++) push(DW'($urandom));
        m_ready = 1'b1;
        base = accepted; lbase = lasts_seen; first_last = -1;
        for (int cyc = 0; cyc < 200 && accepted - base < 20; cyc++) begin
            tick();
            if (first_last < 0 && lasts_seen != lbase) first_last = accepted - base;
        end
        vectors++;
        if (first_last != 16 || accepted - base != 20) begin
            miscompares++;
            $display("FAIL reset_restart: first last at word %0d of %0d required 16 of 20",
                     first_last, accepted - base);
        end
    endtask

    task automatic test_empty();
        for (int cyc = 0; cyc < 100 && (fifo_q.size() != 0 || outstanding != 0); cyc++) tick();
        en = 1'b1;
        for (int cyc = 0; cyc < 100; cyc++) begin
            tick();
            vectors++;
            if (fifo_rd !== 1'b0 || m_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL empty_idle: cycle %0d rd=%0b v=%0b required 0 0", cyc, fifo_rd, m_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_underflow();
        test_stop();
        test_reset_mid();
        test_empty();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
